// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: round count, controller state encoding
// and the linear inverse-round transforms on a FIPS-197 column-major state.
package aes_pkg;

    localparam int unsigned NR = 10;
    localparam int unsigned BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by one of the InvMixColumns constants using an xtime chain.
    function automatic logic [7:0] gf_mul_inv(input logic [7:0] b, input logic [7:0] coef);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (coef)
            8'h09:   return x8 ^ b;
            8'h0b:   return x8 ^ x2 ^ b;
            8'h0d:   return x8 ^ x4 ^ b;
            8'h0e:   return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

    // Byte k of the state sits at bits [127-8k -: 8]; row = k%4, column = k/4.
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul_inv(a0, 8'h0e) ^ gf_mul_inv(a1, 8'h0b) ^
                               gf_mul_inv(a2, 8'h0d) ^ gf_mul_inv(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul_inv(a0, 8'h09) ^ gf_mul_inv(a1, 8'h0e) ^
                               gf_mul_inv(a2, 8'h0b) ^ gf_mul_inv(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul_inv(a0, 8'h0d) ^ gf_mul_inv(a1, 8'h09) ^
                               gf_mul_inv(a2, 8'h0e) ^ gf_mul_inv(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul_inv(a0, 8'h0b) ^ gf_mul_inv(a1, 8'h0d) ^
                               gf_mul_inv(a2, 8'h09) ^ gf_mul_inv(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round; 'last' drops InvMixColumns for the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next_state
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;

    assign shifted = inv_shift_rows(state);

    aes_inv_sbox_layer u_sbox (
        .din  (shifted),
        .dout (subbed)
    );

    assign keyed      = subbed ^ rk;
    assign next_state = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_sbox_layer.sv
// 128-bit inverse S-box layer: sixteen parallel InvSubBytes lookups computed as
// inverse affine transform followed by GF(2^8) inversion (x^254).
module aes_inv_sbox_layer
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y, sq, res;
        logic [7:0] c;
        c = 8'h05;
        for (int i = 0; i < 8; i++) begin
            y[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8] ^ c[i];
        end
        // Square-and-multiply to x^254; maps 0 to 0 as AES requires.
        sq  = y;
        res = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    for (genvar g = 0; g < 16; g++) begin : g_byte
        assign dout[8*g +: 8] = inv_sbox(din[8*g +: 8]);
    end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption controller: one inverse round per clock, round
// keys fetched from an external asynchronous-read key store via rk_idx.
module aes_inv_cipher_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    state_t       state_q, state_d;
    logic [3:0]   r_q, r_d;
    logic [127:0] data_q, data_d;
    logic [127:0] round_out;
    logic         last;

    aes_inv_round u_round (
        .state      (data_q),
        .rk         (rk),
        .last       (last),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            data_q  <= data_d;
        end
    end

    // Next state and state-decoded outputs; rk_idx depends on state and r only.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rk_idx    = 4'(NR);
        last      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    data_d  = in_block ^ rk;
                    r_d     = 4'(NR - 1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                rk_idx = r_q;
                data_d = round_out;
                if (r_q == 4'd1) begin
                    state_d = FINAL;
                end else begin
                    r_d = r_q - 4'd1;
                end
            end
            FINAL: begin
                rk_idx  = 4'd0;
                last    = 1'b1;
                data_d  = round_out;
                state_d = DONE;
            end
            DONE: begin
                rk_idx    = 4'd0;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_block = data_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: FIPS-197 vector, handshake corner cases and a
// randomized regression against a table-driven AES-128 decryption model.
module tb_aes_inv_cipher_ctrl;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;

    logic [127:0] key_store [16];
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    int checks;
    int errors;

    aes_inv_cipher_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    assign rk = key_store[rk_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Forward/inverse S-box tables from brute-force field inversion + affine map.
    task automatic build_tables();
        logic [7:0] inv, b, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            for (int i = 0; i < 8; i++) begin
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbox[x]  = b;
            isbox[b] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 16; k++) key_store[k] = '0;
        for (int k = 0; k < 11; k++) key_store[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        logic [127:0] k;
        k = key_store[10];
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*((c+r)%4)+r] = s[4*c+r];
            k = key_store[rnd];
            for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ k[127-8*i -: 8];
            if (rnd != 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
                    s[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
                    s[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
                    s[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
                end
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Offer one block, watch it through the rounds, then hold DONE for out_stall cycles.
    task automatic do_block(input logic [127:0] ct, input logic [127:0] exp,
                            input bit chk_rk, input int out_stall);
        int n;
        in_block = ct;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 128'(in_ready), 128'd1);
            in_valid = 1'b0;
            return;
        end
        if (chk_rk) check("rk_idle", 128'(rk_idx), 128'd10);
        tick();
        n = 1;
        while (!out_valid && n < 30) begin
            if (chk_rk) check($sformatf("rk_cycle%0d", n), 128'(rk_idx), 128'((n < 10) ? 10 - n : 0));
            in_valid  = 1'($urandom_range(0, 1));
            in_block  = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("latency", 128'(n), 128'd11);
        out_ready = 1'b0;
        for (int s = 0; s < out_stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            tick();
            check("stall_valid", 128'(out_valid), 128'd1);
            check("stall_block", out_block, exp);
            check("stall_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("out_valid", 128'(out_valid), 128'd1);
        check("out_block", out_block, exp);
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] key, ct, exp2, o0, o1;
        int acc, outs, a0, a1;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_block  = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) key_store[k] = '0;
        build_tables();
        tick(); tick(); tick();
        rst = 1'b0;

        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_block", out_block, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'd10);

        expand_key(K1);
        check("model_c1", ref_decrypt(C1), P1);

        // FIPS-197 vector with round-key index sequence and latency
        do_block(C1, P1, 1'b1, 0);
        check("idle_after_done", 128'(in_ready), 128'd1);

        // Backpressure: DONE held for 20 cycles with stray in_valid pulses
        do_block(C1, P1, 1'b0, 20);
        check("bp_idle_busy", 128'(busy), 128'd0);
        check("bp_idle_valid", 128'(out_valid), 128'd0);

        // Back-to-back with in_valid and out_ready held high
        exp2 = ref_decrypt(128'd0);
        in_block = C1; in_valid = 1'b1; out_ready = 1'b1;
        acc = 0; outs = 0; a0 = 0; a1 = 0; o0 = '0; o1 = '0;
        for (int n = 0; n < 60 && outs < 2; n++) begin
            if (in_valid && in_ready) begin
                if (acc == 0) a0 = n; else a1 = n;
                acc++;
            end
            if (out_valid && out_ready) begin
                if (outs == 0) o0 = out_block; else o1 = out_block;
                outs++;
            end
            tick();
            if (acc >= 1) in_block = '0;
            in_valid = (acc < 2);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_count", 128'(outs), 128'd2);
        check("b2b_first", o0, P1);
        check("b2b_second", o1, exp2);
        check("b2b_spacing", 128'(a1 - a0), 128'd12);
        tick();

        // Reset wins over a simultaneous accept
        in_block = C1; in_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rstprio_busy", 128'(busy), 128'd0);
        check("rstprio_block", out_block, 128'd0);

        // Reset while ROUND with r=5
        in_block = C1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 20 && rk_idx != 4'd5; n++) tick();
        check("rst_mid_r5", 128'(rk_idx), 128'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", 128'(busy), 128'd0);
        check("mid_in_ready", 128'(in_ready), 128'd1);
        check("mid_out_valid", 128'(out_valid), 128'd0);
        check("mid_out_block", out_block, 128'd0);
        do_block(C1, P1, 1'b1, 0);

        // Random keys and ciphertexts with random stalls
        for (int i = 0; i < 1000; i++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand_key(key);
            for (int s = $urandom_range(0, 2); s > 0; s--) tick();
            do_block(ct, ref_decrypt(ct), 1'b0, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
